reset_release_seq: RTL and testbench

//  Staged reset-release sequencer on the consumer side of the PLL-lock reset

---
 rtl/reset_release_seq_if.sv | 30 +++
 rtl/reset_release_seq.sv | 166 ++++++++++++++++
 tb/tb_reset_release_seq.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reset_release_seq_if.sv
// Handshake bundle between the reset-release sequencer (master) and the
// blocks it holds in reset (slave).
interface reset_release_seq_if #(
  parameter int NUM_STAGES = 3
) ();
  logic                  pll_locked;
  logic [NUM_STAGES-1:0] stage_done;
  logic [NUM_STAGES-1:0] stage_rst;
  logic                  all_ready;
  logic                  timeout_err;
  logic [2:0]            cur_stage;

  modport master (
    input  pll_locked,
    input  stage_done,
    output stage_rst,
    output all_ready,
    output timeout_err,
    output cur_stage
  );

  modport slave (
    output pll_locked,
    output stage_done,
    input  stage_rst,
    input  all_ready,
    input  timeout_err,
    input  cur_stage
  );
endinterface

// File: rtl/reset_release_seq.sv
// Staged reset-release sequencer: waits for a stable synchronised PLL lock,
// then releases each downstream stage in index order, one done-handshake at a time.
module reset_release_seq #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  reset_release_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_HOLD      = 3'd1,
    S_RELEASE   = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4,
    S_READY     = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]      HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST   = CNT_W'((STAGE_GAP > 0) ? (STAGE_GAP - 1) : 0);
  localparam logic [CNT_W-1:0]      TO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0]            LAST_STAGE = 3'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] RST_ALL    = {NUM_STAGES{1'b1}};

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            cur_stage_q, cur_stage_d;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                  all_ready_q, all_ready_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;

  logic                  lock_s;
  logic [NUM_STAGES-1:0] sel_s;
  logic                  done_cur_s;
  logic [CNT_W-1:0]      cnt_inc_s;

  assign lock_s     = sync2_q;
  assign done_cur_s = |(bus.stage_done & sel_s);
  assign cnt_inc_s  = (&cnt_q) ? cnt_q : (cnt_q + CNT_ONE);

  // One-hot select of the stage being released or awaited
  always_comb begin
    sel_s = {NUM_STAGES{1'b0}};
    for (int i = 0; i < NUM_STAGES; i++) begin
      sel_s[i] = (cur_stage_q == 3'(i));
    end
  end

  // Next-state logic; lock loss overrides everything except the sticky error state
  always_comb begin
    sync1_d       = bus.pll_locked;
    sync2_d       = sync1_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    cur_stage_d   = cur_stage_q;
    stage_rst_d   = stage_rst_q;
    timeout_err_d = timeout_err_q;
    if (!lock_s && (state_q != S_ERROR)) begin
      state_d     = S_WAIT_LOCK;
      cnt_d       = CNT_ZERO;
      cur_stage_d = 3'd0;
      stage_rst_d = RST_ALL;
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          cnt_d   = CNT_ZERO;
          state_d = S_HOLD;
        end
        S_HOLD: begin
          if (cnt_q >= HOLD_LAST) begin
            cnt_d   = CNT_ZERO;
            state_d = S_RELEASE;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        S_RELEASE: begin
          stage_rst_d = stage_rst_q & ~sel_s;
          cnt_d       = CNT_ZERO;
          state_d     = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // done is checked first so a same-cycle done beats the timeout
          if (done_cur_s) begin
            cnt_d = CNT_ZERO;
            if (cur_stage_q >= LAST_STAGE) begin
              state_d = S_READY;
            end else if (STAGE_GAP > 0) begin
              state_d = S_GAP;
            end else begin
              cur_stage_d = cur_stage_q + 3'd1;
              state_d     = S_RELEASE;
            end
          end else if (cnt_q >= TO_LAST) begin
            timeout_err_d = 1'b1;
            stage_rst_d   = RST_ALL;
            state_d       = S_ERROR;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        S_GAP: begin
          if (cnt_q >= GAP_LAST) begin
            cnt_d       = CNT_ZERO;
            cur_stage_d = cur_stage_q + 3'd1;
            state_d     = S_RELEASE;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        S_READY: begin
          state_d = S_READY;
        end
        S_ERROR: begin
          stage_rst_d = RST_ALL;
          state_d     = S_ERROR;
        end
        default: begin
          stage_rst_d = RST_ALL;
          cnt_d       = CNT_ZERO;
          state_d     = S_WAIT_LOCK;
        end
      endcase
    end
    all_ready_d = (state_q == S_READY) && (state_d == S_READY);
  end

  // State, counter, synchroniser and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_WAIT_LOCK;
      cnt_q         <= CNT_ZERO;
      cur_stage_q   <= 3'd0;
      stage_rst_q   <= RST_ALL;
      all_ready_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_stage_q   <= cur_stage_d;
      stage_rst_q   <= stage_rst_d;
      all_ready_q   <= all_ready_d;
      timeout_err_q <= timeout_err_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
    end
  end

  assign bus.stage_rst   = stage_rst_q;
  assign bus.all_ready   = all_ready_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.cur_stage   = cur_stage_q;

endmodule

// File: tb/tb_reset_release_seq.sv
// Bench for reset_release_seq: two configurations driven by directed and random
// lock/done stimulus, checked every cycle against a deadline-based schedule model.
module tb_reset_release_seq;

  localparam int NS    = 3;
  localparam int NEVER = 100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          pll;
  logic [NS-1:0] done_v [2];
  logic [NS-1:0] rst_o  [2];
  logic          rdy_o  [2];
  logic          err_o  [2];
  logic [2:0]    cur_o  [2];

  reset_release_seq_if #(.NUM_STAGES(NS)) bus0 ();
  reset_release_seq_if #(.NUM_STAGES(NS)) bus1 ();

  assign bus0.pll_locked = pll;
  assign bus1.pll_locked = pll;
  assign bus0.stage_done = done_v[0];
  assign bus1.stage_done = done_v[1];
  assign rst_o[0] = bus0.stage_rst;   assign rst_o[1] = bus1.stage_rst;
  assign rdy_o[0] = bus0.all_ready;   assign rdy_o[1] = bus1.all_ready;
  assign err_o[0] = bus0.timeout_err; assign err_o[1] = bus1.timeout_err;
  assign cur_o[0] = bus0.cur_stage;   assign cur_o[1] = bus1.cur_stage;

  reset_release_seq #(.NUM_STAGES(NS), .HOLD_CYCLES(16), .STAGE_GAP(4), .TIMEOUT(1024), .CNT_W(16))
    dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.master));
  reset_release_seq #(.NUM_STAGES(NS), .HOLD_CYCLES(5), .STAGE_GAP(0), .TIMEOUT(8), .CNT_W(8))
    dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.master));

  int H_P [2] = '{16, 5};
  int G_P [2] = '{4, 0};
  int T_P [2] = '{1024, 8};

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // done responder: stage k raises done dly cycles after its reset falls
  int dly  [2][NS];
  bit frc  [2][NS];
  int rcnt [2][NS];

  initial begin
    for (int d = 0; d < 2; d++) begin
      done_v[d] = '0;
      for (int k = 0; k < NS; k++) rcnt[d][k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < NS; k++) begin
          if (rst_o[d][k]) rcnt[d][k] = 0;
          else if (rcnt[d][k] < NEVER) rcnt[d][k]++;
          done_v[d][k] = frc[d][k] || (rcnt[d][k] >= dly[d][k]);
        end
      end
    end
  end

  // schedule model: absolute edge numbers for each release, wait window and ready
  logic [NS-1:0] m_rst [2];
  int m_nrel [2], m_next [2], m_ws [2], m_rdy_at [2];
  bit m_sched [2], m_wait [2], m_err [2], m_rdy [2];
  int fall_at [2][NS];
  int err_at  [2];
  int lock_edge = 0;

  initial begin
    bit p, rn, lk, ph1, ph2, p_prev;
    logic [NS-1:0] dn [2];
    logic [NS-1:0] prev_rst [2];
    bit prev_err [2];
    int exp_cur;
    ph1 = 1'b0; ph2 = 1'b0; p_prev = 1'b0;
    for (int d = 0; d < 2; d++) begin
      prev_rst[d] = '1; prev_err[d] = 1'b0; err_at[d] = 0;
      m_rst[d] = '1; m_nrel[d] = 0; m_sched[d] = 0; m_wait[d] = 0;
      m_err[d] = 0; m_rdy[d] = 0; m_next[d] = 0; m_ws[d] = 0; m_rdy_at[d] = 0;
      for (int k = 0; k < NS; k++) fall_at[d][k] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      p = pll; rn = reset_n; dn[0] = done_v[0]; dn[1] = done_v[1];
      if (!rn) begin
        lk = 1'b0; ph1 = 1'b0; ph2 = 1'b0;
      end else begin
        lk = ph2; ph2 = ph1; ph1 = p;
      end
      if (p && !p_prev) lock_edge = cyc;
      p_prev = p;
      for (int d = 0; d < 2; d++) begin
        if (!rn) begin
          m_rst[d] = '1; m_nrel[d] = 0; m_sched[d] = 0; m_wait[d] = 0; m_err[d] = 0; m_rdy[d] = 0;
        end else if (m_err[d]) begin
          m_rst[d] = '1;
        end else if (!lk) begin
          m_rst[d] = '1; m_nrel[d] = 0; m_sched[d] = 0; m_wait[d] = 0; m_rdy[d] = 0;
        end else if (m_wait[d]) begin
          if (dn[d][m_nrel[d]-1]) begin
            m_wait[d] = 0;
            if (m_nrel[d] == NS) begin
              m_rdy[d] = 1; m_rdy_at[d] = cyc + 1;
            end else begin
              m_sched[d] = 1; m_next[d] = cyc + G_P[d] + 1;
            end
          end else if (cyc == m_ws[d] + T_P[d]) begin
            m_err[d] = 1; m_rst[d] = '1; m_wait[d] = 0;
          end
        end else if (m_sched[d]) begin
          if (cyc == m_next[d]) begin
            m_rst[d][m_nrel[d]] = 1'b0;
            m_nrel[d]++; m_sched[d] = 0; m_wait[d] = 1; m_ws[d] = cyc;
          end
        end else if (m_nrel[d] == 0) begin
          m_sched[d] = 1; m_next[d] = cyc + H_P[d] + 1;
        end
      end
      #2;
      for (int d = 0; d < 2; d++) begin
        if (m_nrel[d] == 0) exp_cur = 0;
        else if (m_sched[d] && cyc >= m_next[d] - 1) exp_cur = m_nrel[d];
        else exp_cur = m_nrel[d] - 1;
        chk($sformatf("stage_rst[d%0d]", d), int'(rst_o[d]), int'(m_rst[d]));
        chk($sformatf("all_ready[d%0d]", d), int'(rdy_o[d]), int'(m_rdy[d] && cyc >= m_rdy_at[d]));
        chk($sformatf("timeout_err[d%0d]", d), int'(err_o[d]), int'(m_err[d]));
        chk($sformatf("cur_stage[d%0d]", d), int'(cur_o[d]), exp_cur);
        for (int k = 0; k < NS; k++)
          if (prev_rst[d][k] && !rst_o[d][k]) fall_at[d][k] = cyc;
        if (err_o[d] && !prev_err[d]) err_at[d] = cyc;
        prev_rst[d] = rst_o[d];
        prev_err[d] = err_o[d];
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    pll     = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic set_dly(input int d, input int a, input int b, input int c);
    dly[d][0] = a; dly[d][1] = b; dly[d][2] = c;
  endtask

  initial begin
    int w;
    reset_n = 1'b0;
    pll     = 1'b1;
    for (int d = 0; d < 2; d++) begin
      set_dly(d, NEVER, NEVER, NEVER);
      for (int k = 0; k < NS; k++) frc[d][k] = 1'b0;
    end

    // reset held with lock present
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_rst", int'(rst_o[0]), 7);
      chk("t1_ready", int'(rdy_o[0]), 0);
      chk("t1_err", int'(err_o[0]), 0);
      chk("t1_cur", int'(cur_o[0]), 0);
    end

    // nominal sequence
    set_dly(0, 5, 5, 5); set_dly(1, 5, 5, 5);
    apply_reset();
    repeat (3) @(negedge clk);
    pll = 1'b1;
    w = 0;
    while (!(rdy_o[0] && rdy_o[1]) && w < 400) begin @(negedge clk); w++; end
    chk("t2_ready_wait", int'(w < 400), 1);
    chk("t2_first_fall_d0", fall_at[0][0] - lock_edge, 19);
    chk("t2_gap01_d0", fall_at[0][1] - fall_at[0][0], 10);
    chk("t2_gap12_d0", fall_at[0][2] - fall_at[0][1], 10);
    chk("t2_first_fall_d1", fall_at[1][0] - lock_edge, 8);
    chk("t2_gap01_d1", fall_at[1][1] - fall_at[1][0], 6);

    // stage 1 never answers
    set_dly(0, 5, NEVER, 5); set_dly(1, 5, NEVER, 5);
    apply_reset();
    pll = 1'b1;
    w = 0;
    while (!err_o[0] && w < 1300) begin @(negedge clk); w++; end
    chk("t3_err_wait", int'(w < 1300), 1);
    chk("t3_err_latency", err_at[0] - fall_at[0][1], 1024);
    chk("t3_rst_all", int'(rst_o[0]), 7);
    pll = 1'b0;
    repeat (5) @(negedge clk);
    pll = 1'b1;
    repeat (5) @(negedge clk);
    chk("t3_err_sticky", int'(err_o[0]), 1);
    chk("t3_rst_sticky", int'(rst_o[0]), 7);
    apply_reset();
    @(negedge clk);
    chk("t3_err_cleared", int'(err_o[0]), 0);

    // lock loss while waiting for stage 1
    set_dly(0, 3, 40, 3); set_dly(1, 3, 40, 3);
    apply_reset();
    pll = 1'b1;
    w = 0;
    while (rst_o[0][1] && w < 200) begin @(negedge clk); w++; end
    chk("t4_rel1_wait", int'(w < 200), 1);
    repeat (5) @(negedge clk);
    pll = 1'b0;
    w = 0;
    while (rst_o[0] != 3'b111 && w < 10) begin @(negedge clk); w++; end
    chk("t4_drop_latency_le3", int'(w <= 3), 1);
    chk("t4_cur0", int'(cur_o[0]), 0);
    set_dly(0, 3, 3, 3);
    pll = 1'b1;
    w = 0;
    while (!rdy_o[0] && w < 300) begin @(negedge clk); w++; end
    chk("t4_reseq_ready", int'(rdy_o[0]), 1);

    // one-cycle lock glitch during hold
    set_dly(0, 5, 5, 5); set_dly(1, 5, 5, 5);
    apply_reset();
    pll = 1'b1;
    repeat (8) @(negedge clk);
    pll = 1'b0;
    @(negedge clk);
    pll = 1'b1;
    w = 0;
    while (rst_o[0][0] && w < 100) begin @(negedge clk); w++; end
    chk("t5_restart_fall", fall_at[0][0] - lock_edge, 19);

    // done pre-asserted, zero gap, done coinciding with timeout
    set_dly(0, 5, 5, NEVER); set_dly(1, 8, 2, NEVER);
    frc[0][2] = 1'b1; frc[1][2] = 1'b1;
    apply_reset();
    pll = 1'b1;
    w = 0;
    while (!rdy_o[1] && w < 200) begin @(negedge clk); w++; end
    chk("t6_ready_d1", int'(rdy_o[1]), 1);
    chk("t6_no_err_d1", int'(err_o[1]), 0);
    chk("t6_gap12_d1", fall_at[1][2] - fall_at[1][1], 3);
    frc[0][2] = 1'b0; frc[1][2] = 1'b0;

    // randomized lock behaviour and done delays
    for (int r = 0; r < 8; r++) begin
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < NS; k++) begin
          dly[d][k] = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 9));
          frc[d][k] = ($urandom_range(0, 7) == 0);
        end
      apply_reset();
      pll = 1'b1;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (pll) begin
          if ($urandom_range(0, 59) == 0) pll = 1'b0;
        end else begin
          if ($urandom_range(0, 4) == 0) pll = 1'b1;
        end
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
